prog_loader: RTL and testbench

UART boot sequencer between the host-side `uart_rx` and the core inside `top_wrap`. It takes a big-endian 32-bit program byte count, then the program bytes. It packs those bytes into little-endian 32-bit words and writes them into instruction memory. Once the program is loaded it sends one acknowledge byte, releases the CPU, and forwards every later byte to the core's input FIFO.

---
 rtl/prog_loader.sv | 205 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: UART boot sequencer. Receives a big-endian 32-bit byte count,
// packs the following program bytes into little-endian words for instruction
// memory, sends one acknowledge byte, releases the CPU and then forwards every
// later byte to the core's input FIFO.
module prog_loader #(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
    input  logic              clk_uart,
    input  logic              rstn,
    input  logic [7:0]        rdata,
    input  logic              rdata_ready,
    input  logic              ferr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              cpu_start,
    output logic [7:0]        din_data,
    output logic              din_we,
    input  logic              din_full,
    output logic              err,
    output logic              overrun
);

    typedef enum logic [2:0] {
        ST_SIZE,
        ST_PROG,
        ST_PAD,
        ST_ACK,
        ST_RUN,
        ST_ERR
    } state_e;

    state_e              state_q;
    logic [31:0]         size_q;
    logic [1:0]          size_cnt_q;
    logic [31:0]         byte_cnt_q;
    logic [ADDR_W:0]     word_cnt_q;   // one spare bit flags an index past capacity
    logic [31:0]         asm_q;
    logic                skid_valid_q;
    logic [7:0]          skid_data_q;

    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic [7:0]          tx_data_q;
    logic                tx_start_q;
    logic                cpu_start_q;
    logic [7:0]          din_data_q;
    logic                din_we_q;
    logic                err_q;
    logic                overrun_q;

    logic [31:0]         size_d;
    logic [31:0]         asm_d;
    logic [1:0]          lane;
    logic                last_byte;
    logic                oversize;
    logic                rx_ok;
    logic                push_valid;
    logic [7:0]          push_data;

    // Next-value helpers: size shift, word assembly and the RUN push source.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        size_d     = {size_q[23:0], rdata};
        lane       = byte_cnt_q[1:0];
        asm_d      = (lane == 2'd0) ? 32'd0 : asm_q;
        asm_d[{lane, 3'b000} +: 8] = rdata;
        last_byte  = (byte_cnt_q + 32'd1) == size_q;
        oversize   = word_cnt_q[ADDR_W];
        rx_ok      = rdata_ready && !ferr;
        push_valid = skid_valid_q || rx_ok;
        push_data  = skid_valid_q ? skid_data_q : rdata;
    end

    // Loader state machine with registered outputs and synchronous reset.
    always_ff @(posedge clk_uart) begin
        // NOTE: all state here is updated with non-blocking assignments so every
        // branch sees the values from the start of the cycle.
        if (!rstn) begin
            state_q      <= ST_SIZE;
            size_q       <= '0;
            size_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            asm_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            cpu_start_q  <= 1'b0;
            din_data_q   <= '0;
            din_we_q     <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            imem_we_q  <= 1'b0;
            tx_start_q <= 1'b0;
            din_we_q   <= 1'b0;

            // Bytes arriving while the write-back or acknowledge is pending
            // belong to the data stream and wait in the skid register.
            if ((state_q == ST_PAD || state_q == ST_ACK) && rx_ok) begin
                if (skid_valid_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    skid_valid_q <= 1'b1;
                    skid_data_q  <= rdata;
                end
            end

            case (state_q)
                ST_SIZE: begin
                    if (rdata_ready) begin
                        if (ferr) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            size_q     <= size_d;
                            size_cnt_q <= size_cnt_q + 2'd1;
                            if (size_cnt_q == 2'd3)
                                state_q <= (size_d == 32'd0) ? ST_ACK : ST_PROG;
                        end
                    end
                end
                ST_PROG: begin
                    if (rdata_ready) begin
                        if (ferr || oversize) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            asm_q      <= asm_d;
                            byte_cnt_q <= byte_cnt_q + 32'd1;
                            if (lane == 2'd3) begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                                imem_wdata_q <= asm_d;
                                word_cnt_q   <= word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                            end
                            if (last_byte)
                                state_q <= (lane == 2'd3) ? ST_ACK : ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    // Unfilled lanes are already zero: lane 0 starts a fresh word.
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                    imem_wdata_q <= asm_q;
                    word_cnt_q   <= word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                    state_q      <= ST_ACK;
                end
                ST_ACK: begin
                    if (!tx_busy) begin
                        tx_start_q  <= 1'b1;
                        tx_data_q   <= ACK_BYTE;
                        cpu_start_q <= 1'b1;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A buffered byte goes first; a byte arriving alongside it
                    // takes its place in the skid register.
                    if (push_valid) begin
                        if (!din_full) begin
                            din_we_q   <= 1'b1;
                            din_data_q <= push_data;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                    if (skid_valid_q) begin
                        if (rx_ok)
                            skid_data_q <= rdata;
                        else
                            skid_valid_q <= 1'b0;
                    end
                end
                ST_ERR: begin
                    // Terminal until reset.
                end
                default: state_q <= ST_ERR;
            endcase
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign cpu_start  = cpu_start_q;
    assign din_data   = din_data_q;
    assign din_we     = din_we_q;
    assign err        = err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: program loads, padding, zero-size boot,
// delayed acknowledge with skid byte, framing error recovery, FIFO overrun
// and oversize detection.
module tb_prog_loader;

    localparam int ADDR_W = 12;

    logic              clk_uart = 1'b0;
    logic              rstn = 1'b0;
    logic [7:0]        rdata = 8'h00;
    logic              rdata_ready = 1'b0;
    logic              ferr = 1'b0;
    logic              tx_busy = 1'b0;
    logic              din_full = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              cpu_start;
    logic [7:0]        din_data;
    logic              din_we;
    logic              err;
    logic              overrun;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  din_q[$];
    int          tx_cnt = 0;

    prog_loader #(.ADDR_W(ADDR_W), .ACK_BYTE(8'hAA)) dut (
        .clk_uart    (clk_uart),
        .rstn        (rstn),
        .rdata       (rdata),
        .rdata_ready (rdata_ready),
        .ferr        (ferr),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .cpu_start   (cpu_start),
        .din_data    (din_data),
        .din_we      (din_we),
        .din_full    (din_full),
        .err         (err),
        .overrun     (overrun)
    );

    always #5 clk_uart = ~clk_uart;

    // Log every strobe on the falling edge, away from the active edge.
    always @(negedge clk_uart) begin
        if (rstn) begin
            if (imem_we) begin
                wr_addr_q.push_back(32'(imem_addr));
                wr_data_q.push_back(imem_wdata);
            end
            if (din_we) din_q.push_back(din_data);
            if (tx_start) tx_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_uart);
    endtask

    task automatic do_reset(input int cycles);
        rstn        = 1'b0;
        rdata_ready = 1'b0;
        ferr        = 1'b0;
        repeat (cycles) @(negedge clk_uart);
        wr_addr_q.delete();
        wr_data_q.delete();
        din_q.delete();
        tx_cnt = 0;
        rstn   = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after the byte
    // was sampled, so registered responses are already visible.
    task automatic send(input logic [7:0] b, input logic fe);
        rdata       = b;
        ferr        = fe;
        rdata_ready = 1'b1;
        @(negedge clk_uart);
        rdata_ready = 1'b0;
        ferr        = 1'b0;
    endtask

    task automatic send_size(input logic [31:0] s);
        send(s[31:24], 1'b0);
        send(s[23:16], 1'b0);
        send(s[15:8],  1'b0);
        send(s[7:0],   1'b0);
    endtask

    function automatic logic [7:0] t1_byte(input int i);
        return 8'(i * 3 + 1);
    endfunction

    initial begin
        logic [31:0] exp_w;

        // Reset state
        do_reset(2);
        check("rst_imem_we",   32'(imem_we),   32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wd",   imem_wdata,     32'd0);
        check("rst_tx",        {tx_data, 7'd0, tx_start}, 32'd0);
        check("rst_cpu",       32'(cpu_start), 32'd0);
        check("rst_din",       {din_data, 7'd0, din_we}, 32'd0);
        check("rst_flags",     {err, overrun}, 32'd0);

        // 108-byte program: 27 full words
        send_size(32'd108);
        for (int i = 0; i < 108; i++) send(t1_byte(i), 1'b0);
        idle(5);
        check("t1_nwr", 32'(wr_addr_q.size()), 32'd27);
        check("t1_w0", wr_data_q[0], 32'h0A070401);
        check("t1_w26", wr_data_q[26], 32'h423F3C39);
        for (int w = 0; w < 27; w++) begin
            exp_w = {t1_byte(4*w+3), t1_byte(4*w+2), t1_byte(4*w+1), t1_byte(4*w)};
            check($sformatf("t1_a%0d", w), wr_addr_q[w], 32'(w));
            check($sformatf("t1_d%0d", w), wr_data_q[w], exp_w);
        end
        check("t1_txcnt", 32'(tx_cnt), 32'd1);
        check("t1_txdata", 32'(tx_data), 32'hAA);
        check("t1_cpu", 32'(cpu_start), 32'd1);

        // 6-byte program: one full word plus a padded word
        do_reset(2);
        send_size(32'd6);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        check("t2_we_lat", 32'(imem_we), 32'd1);
        check("t2_wd_lat", imem_wdata, 32'h44332211);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        idle(5);
        check("t2_nwr", 32'(wr_addr_q.size()), 32'd2);
        check("t2_a0", wr_addr_q[0], 32'd0);
        check("t2_d0", wr_data_q[0], 32'h44332211);
        check("t2_a1", wr_addr_q[1], 32'd1);
        check("t2_d1", wr_data_q[1], 32'h00006655);
        check("t2_txcnt", 32'(tx_cnt), 32'd1);

        // Zero size, then 10 data bytes back-to-back
        do_reset(2);
        send_size(32'd0);
        for (int i = 0; i < 10; i++) send(8'(8'hC0 + i), 1'b0);
        idle(5);
        check("t3_nwr", 32'(wr_addr_q.size()), 32'd0);
        check("t3_txcnt", 32'(tx_cnt), 32'd1);
        check("t3_ndin", 32'(din_q.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("t3_din%0d", i), 32'(din_q[i]), 32'(8'hC0 + i));
        check("t3_ovr", 32'(overrun), 32'd0);

        // Acknowledge held off by a busy transmitter, one byte buffered
        do_reset(2);
        tx_busy = 1'b1;
        send_size(32'd0);
        idle(10);
        send(8'h5A, 1'b0);
        idle(38);
        check("t4_no_tx", 32'(tx_cnt), 32'd0);
        check("t4_no_cpu", 32'(cpu_start), 32'd0);
        check("t4_no_din", 32'(din_q.size()), 32'd0);
        tx_busy = 1'b0;
        @(negedge clk_uart);
        check("t4_tx_start", 32'(tx_start), 32'd1);
        check("t4_tx_data", 32'(tx_data), 32'hAA);
        check("t4_cpu_rise", 32'(cpu_start), 32'd1);
        @(negedge clk_uart);
        check("t4_skid_we", 32'(din_we), 32'd1);
        check("t4_skid_data", 32'(din_data), 32'h5A);
        check("t4_tx_pulse", 32'(tx_start), 32'd0);

        // Framing error on the second size byte, then a clean reload
        do_reset(2);
        send(8'h00, 1'b0);
        send(8'h12, 1'b1);
        check("t5_err", 32'(err), 32'd1);
        send(8'h00, 1'b0);
        send(8'h04, 1'b0);
        for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
        idle(3);
        check("t5_err_nwr", 32'(wr_addr_q.size()), 32'd0);
        check("t5_err_cpu", 32'(cpu_start), 32'd0);
        check("t5_err_tx", 32'(tx_cnt), 32'd0);
        do_reset(1);
        check("t5_err_clr", 32'(err), 32'd0);
        send_size(32'd4);
        for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
        idle(4);
        check("t5_nwr", 32'(wr_addr_q.size()), 32'd1);
        check("t5_d0", wr_data_q[0], 32'h04030201);
        check("t5_cpu", 32'(cpu_start), 32'd1);

        // FIFO full in RUN: bytes dropped and overrun set
        din_full = 1'b1;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        idle(2);
        check("t6_ndin_full", 32'(din_q.size()), 32'd0);
        check("t6_ovr", 32'(overrun), 32'd1);
        din_full = 1'b0;
        send(8'h77, 1'b0);
        idle(2);
        check("t6_ndin", 32'(din_q.size()), 32'd1);
        check("t6_din0", 32'(din_q[0]), 32'h77);

        // Oversize: size 2^ADDR_W*4+4, error on byte index 2^ADDR_W*4
        do_reset(2);
        send_size(32'h0000_4004);
        for (int i = 0; i < 16384; i++) send(8'(i), 1'b0);
        idle(3);
        check("t7_nwr_full", 32'(wr_addr_q.size()), 32'd4096);
        check("t7_no_err", 32'(err), 32'd0);
        check("t7_d0", wr_data_q[0], 32'h03020100);
        check("t7_alast", wr_addr_q[4095], 32'd4095);
        check("t7_dlast", wr_data_q[4095], 32'hFFFEFDFC);
        send(8'hEE, 1'b0);
        check("t7_err", 32'(err), 32'd1);
        check("t7_err_we", 32'(imem_we), 32'd0);
        idle(3);
        check("t7_nwr_after", 32'(wr_addr_q.size()), 32'd4096);
        check("t7_tx", 32'(tx_cnt), 32'd0);
        check("t7_cpu", 32'(cpu_start), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
